lc4_div_seq: RTL and testbench

LC4_DIV_SEQ -- requirements
Module: lc4_div_seq

---
 rtl/lc4_div_seq_pkg.sv | 18 +
 rtl/lc4_div_seq_if.sv | 20 ++
 rtl/lc4_div_seq_cla16.sv | 47 ++++
 rtl/lc4_div_seq.sv | 116 +++++++++++
 tb/tb_lc4_div_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/lc4_div_seq_pkg.sv
// Shared LC4 divider definitions: FSM encodings, iteration count, helpers.
package lc4_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITERS = 16;
  localparam logic [3:0] LAST_ITER = 4'(DIV_ITERS - 1);

  // Majority of three: carry-out of a single full-adder bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/lc4_div_seq_if.sv
// Request/result bundle of the sequential LC4 divider.
interface lc4_div_seq_if;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_done, o_quotient, o_remainder
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_done, o_quotient, o_remainder
  );
endinterface

// File: rtl/lc4_div_seq_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups plus a group
// lookahead level. No carry-out port; callers that need it recover it
// from bit 15.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  // Carry into each group, fully expanded so no group waits on another.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      // In-group carries from the group carry-in.
      assign c[B]     = grp_c[gi];
      assign c[B + 1] = g[B] | (p[B] & grp_c[gi]);
      assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & grp_c[gi]);
      assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                      | (p[B + 2] & p[B + 1] & p[B] & grp_c[gi]);
      // The top group's generate/propagate would only feed a carry-out.
      if (gi < 3) begin : g_gp
        assign grp_g[gi] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                         | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
        assign grp_p[gi] = &p[B + 3:B];
      end
    end
  endgenerate

  assign sum = p ^ c;
endmodule

// File: rtl/lc4_div_seq.sv
// Sequential 16-bit unsigned restoring divider with LC4 DIV/MOD semantics
// (divide by zero yields 0/0). One quotient bit per RUN cycle.
module lc4_div_seq
  import lc4_div_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  lc4_div_seq_if.slave  bus
);
  div_state_e  state_q, state_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] dsr_q, dsr_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] rmd_q, rmd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] shifted;
  logic        top;
  logic [15:0] diff;
  logic        cout;
  logic        take;
  logic        accept;

  // Trial subtraction shifted - divisor as shifted + ~divisor + 1.
  cla16 u_cla (
    .a   (shifted),
    .b   (~dsr_q),
    .cin (1'b1),
    .sum (diff)
  );

  // One restoring step plus the start/finish sequencing.
  always_comb begin
    shifted = {rem_q[14:0], dvd_q[15]};
    top     = rem_q[15];
    cout    = maj3(shifted[15], ~dsr_q[15], diff[15] ^ shifted[15] ^ ~dsr_q[15]);
    take    = top | cout;
    accept  = bus.i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    case (state_q)
      ST_RUN: begin
        dvd_d = {dvd_q[14:0], take};
        rem_d = take ? diff : shifted;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          quo_d   = {dvd_q[14:0], take};
          rmd_d   = take ? diff : shifted;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise drops to IDLE.
        if (accept) begin
          if (bus.i_divisor != 16'h0000) begin
            state_d = ST_RUN;
            dvd_d   = bus.i_dividend;
            dsr_d   = bus.i_divisor;
            rem_d   = 16'h0000;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_DONE;
            quo_d   = 16'h0000;
            rmd_d   = 16'h0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= 16'h0000;
      dsr_q   <= 16'h0000;
      rem_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      quo_q   <= 16'h0000;
      rmd_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_quotient  = quo_q;
  assign bus.o_remainder = rmd_q;
endmodule

// File: tb/tb_lc4_div_seq.sv
// Directed bench for lc4_div_seq: hand-computed quotients/remainders and
// cycle-exact busy/done timing.
module tb_lc4_div_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   busy_cnt;
  int   done_at;
  int   seen_done;

  lc4_div_seq_if bus ();

  lc4_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then release i_start.
  task automatic start_op(input logic [15:0] dvd, input logic [15:0] dsr);
    bus.i_start    = 1'b1;
    bus.i_dividend = dvd;
    bus.i_divisor  = dsr;
    tick();
    bus.i_start    = 1'b0;
    bus.i_dividend = 16'hDEAD;
    bus.i_divisor  = 16'hBEEF;
  endtask

  // From cycle index n0 after acceptance, wait (bounded) for o_done.
  task automatic wait_done(input int n0, output int at, output int bcnt);
    int n;
    n    = n0;
    bcnt = 0;
    while (!bus.o_done && n < 40) begin
      if (bus.o_busy) bcnt++;
      tick();
      n++;
    end
    at = bus.o_done ? n : -1;
  endtask

  task automatic run_check(input string tag, input logic [15:0] dvd, input logic [15:0] dsr,
                           input int exp_at, input int exp_busy,
                           input logic [15:0] exp_q, input logic [15:0] exp_r);
    int at;
    int bc;
    start_op(dvd, dsr);
    wait_done(1, at, bc);
    $display("txn %s: %0d / %0d -> q=0x%04h r=0x%04h done_at=%0d busy=%0d",
             tag, dvd, dsr, bus.o_quotient, bus.o_remainder, at, bc);
    chk({tag, "_done_at"}, at, exp_at);
    chk({tag, "_busy_cycles"}, bc, exp_busy);
    chk({tag, "_q"}, bus.o_quotient, exp_q);
    chk({tag, "_r"}, bus.o_remainder, exp_r);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b1;
    bus.i_dividend = 16'd100;
    bus.i_divisor  = 16'd7;
    tick();
    tick();
    // start held during reset must be ignored
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_q", bus.o_quotient, 16'h0000);
    chk("rst_r", bus.o_remainder, 16'h0000);
    bus.i_start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_busy", bus.o_busy, 1'b0);

    run_check("d100_7", 16'd100, 16'd7, 17, 16, 16'h000E, 16'h0002);
    tick();
    chk("d100_7_done_low", bus.o_done, 1'b0);
    chk("d100_7_idle", bus.o_busy, 1'b0);

    run_check("dFFFF_1", 16'hFFFF, 16'h0001, 17, 16, 16'hFFFF, 16'h0000);
    tick();
    run_check("dFFFF_8000", 16'hFFFF, 16'h8000, 17, 16, 16'h0001, 16'h7FFF);
    tick();

    run_check("d5_0", 16'd5, 16'd0, 1, 0, 16'h0000, 16'h0000);
    tick();
    chk("d5_0_done_low", bus.o_done, 1'b0);
    chk("d5_0_busy_low", bus.o_busy, 1'b0);

    // Start pulse during RUN must not disturb the in-flight divide.
    start_op(16'd3, 16'd10);
    chk("d3_10_busy", bus.o_busy, 1'b1);
    start_op(16'd50, 16'd5);
    wait_done(2, done_at, busy_cnt);
    $display("txn d3_10: q=0x%04h r=0x%04h done_at=%0d", bus.o_quotient, bus.o_remainder, done_at);
    chk("d3_10_done_at", done_at, 17);
    chk("d3_10_q", bus.o_quotient, 16'h0000);
    chk("d3_10_r", bus.o_remainder, 16'h0003);

    // Back-to-back start accepted in the DONE cycle.
    start_op(16'd50, 16'd5);
    chk("b2b_done_low", bus.o_done, 1'b0);
    chk("b2b_busy", bus.o_busy, 1'b1);
    wait_done(1, done_at, busy_cnt);
    $display("txn d50_5: q=0x%04h r=0x%04h done_at=%0d", bus.o_quotient, bus.o_remainder, done_at);
    chk("b2b_done_at", done_at, 17);
    chk("b2b_q", bus.o_quotient, 16'h000A);
    chk("b2b_r", bus.o_remainder, 16'h0000);
    tick();

    // Reset in the middle of a divide: aborted, no done pulse.
    start_op(16'd1000, 16'd3);
    for (int i = 0; i < 7; i++) tick();
    chk("abort_busy_pre", bus.o_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_done) seen_done++;
      tick();
    end
    $display("txn abort: q=0x%04h r=0x%04h done_pulses=%0d", bus.o_quotient, bus.o_remainder, seen_done);
    chk("abort_no_done", seen_done, 0);
    chk("abort_busy", bus.o_busy, 1'b0);
    chk("abort_q", bus.o_quotient, 16'h0000);
    chk("abort_r", bus.o_remainder, 16'h0000);

    run_check("d1000_3", 16'd1000, 16'd3, 17, 16, 16'h014D, 16'h0001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
